// File: rtl/serial_adder_datapath_if.sv
// ---------------------------------------------------------------------------
// serial_adder_datapath_if
//
// Purpose: bundles the control strobes, operands and results exchanged
//          between the serial-adder controller side and the bit-serial
//          datapath. Clock and reset are kept off the interface and stay
//          plain module ports.
//
// Signals:
//   LOAD     controller -> datapath  parallel-load strobe
//   EN       controller -> datapath  shift enable
//   A_IN     controller -> datapath  operand A (WIDTH bits)
//   B_IN     controller -> datapath  operand B (WIDTH bits)
//   CIN      controller -> datapath  carry-in, captured on load
//   SUM_BIT  datapath -> controller  current serial sum bit (combinational)
//   SUM      datapath -> controller  registered parallel result
//   COUT     datapath -> controller  registered final carry
//   DONE     datapath -> controller  result valid
//   BUSY     datapath -> controller  operands armed / shifting
//
// Modports:
//   master   drives LOAD/EN/operands, observes results (controller, bench)
//   slave    the datapath itself
// ---------------------------------------------------------------------------
interface serial_adder_datapath_if #(
  parameter int WIDTH = 8
);

  logic             LOAD;
  logic             EN;
  logic [WIDTH-1:0] A_IN;
  logic [WIDTH-1:0] B_IN;
  logic             CIN;
  logic             SUM_BIT;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             DONE;
  logic             BUSY;

  modport master (
    output LOAD,
    output EN,
    output A_IN,
    output B_IN,
    output CIN,
    input  SUM_BIT,
    input  SUM,
    input  COUT,
    input  DONE,
    input  BUSY
  );

  modport slave (
    input  LOAD,
    input  EN,
    input  A_IN,
    input  B_IN,
    input  CIN,
    output SUM_BIT,
    output SUM,
    output COUT,
    output DONE,
    output BUSY
  );

endinterface

// File: rtl/serial_adder_datapath.sv
// ---------------------------------------------------------------------------
// serial_adder_datapath
//
// Purpose: bit-serial adder datapath. Two WIDTH-bit operands and a carry-in
//          are parallel-loaded, then added LSB-first, one bit per enabled
//          cycle, through a single full adder and a carry flop. After WIDTH
//          enabled cycles the parallel sum and carry-out are presented and
//          DONE is raised. An internal bit counter makes the block immune to
//          extra enable cycles and enable pauses from the controller.
//
// Parameters:
//   WIDTH    operand / sum width in bits (>= 2)
//
// Ports:
//   CLK      in   rising-edge clock
//   RST      in   asynchronous, active-low reset
//   bus      slave modport of serial_adder_datapath_if:
//              LOAD, EN, A_IN, B_IN, CIN          (inputs)
//              SUM_BIT, SUM, COUT, DONE, BUSY     (outputs)
// ---------------------------------------------------------------------------
module serial_adder_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  serial_adder_datapath_if.slave  bus
);

  // Counter must be able to hold the value WIDTH-1 with headroom up to WIDTH.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CPLT  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             done_q;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] s_next;
  logic             last_bit;

  // Single full adder on the LSBs of the operand shift registers.
  assign sum_bit    = a_sr[0] ^ b_sr[0] ^ c;
  assign carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);

  // Sum bits enter at the MSB so that after WIDTH shifts the LSB produced
  // first has travelled down to bit 0.
  assign s_next     = {sum_bit, s_sr[WIDTH-1:1]};

  // The shift that happens while cnt==WIDTH-1 is the final one.
  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));

  // State, shift registers, counter and registered results all live in one
  // block. LOAD wins over everything, so a reload during a shift restarts
  // cleanly without performing a shift on the same edge. SUM/COUT are only
  // written at completion, so a previous result stays visible until the next
  // addition finishes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else if (bus.LOAD) begin
      state  <= SHIFT;
      a_sr   <= bus.A_IN;
      b_sr   <= bus.B_IN;
      s_sr   <= '0;
      c      <= bus.CIN;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          if (bus.EN) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            s_sr <= s_next;
            c    <= carry_next;
            cnt  <= cnt + CNT_W'(1);
            if (last_bit) begin
              sum_q  <= s_next;
              cout_q <= carry_next;
              done_q <= 1'b1;
              state  <= CPLT;
            end
          end
        end
        CPLT: begin
          // Result holds; trailing enables from the controller are absorbed.
          state <= CPLT;
        end
        default: begin
          // IDLE: nothing armed, enables are ignored.
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.SUM_BIT = sum_bit;
  assign bus.SUM     = sum_q;
  assign bus.COUT    = cout_q;
  assign bus.DONE    = done_q;
  assign bus.BUSY    = (state == SHIFT);

endmodule

// File: tb/tb_serial_adder_datapath.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_datapath
//
// Purpose: directed, self-checking bench for serial_adder_datapath with
//          WIDTH=8. Drives the datapath through the interface master side
//          and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_serial_adder_datapath;

  localparam int WIDTH = 8;

  logic CLK;
  logic RST;

  int total;
  int bad;

  serial_adder_datapath_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_datapath #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle of inputs, take the rising edge, settle 1 time unit after.
  task automatic apply_stimulus(input logic load, input logic en,
                                input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b,
                                input logic cin);
    bus.LOAD = load;
    bus.EN   = en;
    bus.A_IN = a;
    bus.B_IN = b;
    bus.CIN  = cin;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b0;
    bus.LOAD = 1'b0;
    bus.EN   = 1'b0;
    bus.A_IN = '0;
    bus.B_IN = '0;
    bus.CIN  = 1'b0;

    // Reset state
    #1;
    check_output("rst_sum",  32'(bus.SUM),  32'h00);
    check_output("rst_cout", 32'(bus.COUT), 32'h0);
    check_output("rst_done", 32'(bus.DONE), 32'h0);
    check_output("rst_busy", 32'(bus.BUSY), 32'h0);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    check_output("idle_en_busy", 32'(bus.BUSY), 32'h0);

    // Basic add 0x5A + 0x33 = 0x08D; operand inputs scrambled while shifting
    $display("[TB] basic add");
    apply_stimulus(1'b1, 1'b0, 8'h5A, 8'h33, 1'b0);
    check_output("basic_load_busy", 32'(bus.BUSY), 32'h1);
    check_output("basic_load_done", 32'(bus.DONE), 32'h0);
    check_output("basic_first_sumbit", 32'(bus.SUM_BIT), 32'h1);
    for (int i = 1; i <= 7; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
      check_output("basic_mid_busy", 32'(bus.BUSY), 32'h1);
      check_output("basic_mid_done", 32'(bus.DONE), 32'h0);
    end
    apply_stimulus(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    check_output("basic_done", 32'(bus.DONE), 32'h1);
    check_output("basic_sum",  32'(bus.SUM),  32'h8D);
    check_output("basic_cout", 32'(bus.COUT), 32'h0);
    check_output("basic_busy_end", 32'(bus.BUSY), 32'h0);
    apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    check_output("basic_extra_done", 32'(bus.DONE), 32'h1);
    check_output("basic_extra_sum",  32'(bus.SUM),  32'h8D);
    check_output("basic_extra_busy", 32'(bus.BUSY), 32'h0);

    // Carry ripple 0xFF + 0x01 = 0x100
    $display("[TB] carry ripple");
    apply_stimulus(1'b1, 1'b0, 8'hFF, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    check_output("ripple_sum",  32'(bus.SUM),  32'h00);
    check_output("ripple_cout", 32'(bus.COUT), 32'h1);
    check_output("ripple_done", 32'(bus.DONE), 32'h1);

    // Carry-in 0xFF + 0xFF + 1 = 0x1FF
    $display("[TB] carry in");
    apply_stimulus(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);
    check_output("cin_first_sumbit", 32'(bus.SUM_BIT), 32'h1);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    check_output("cin_sum",  32'(bus.SUM),  32'hFF);
    check_output("cin_cout", 32'(bus.COUT), 32'h1);

    // Pause: 0x0F + 0x01 = 0x010 with a 3-cycle enable gap
    $display("[TB] pause");
    apply_stimulus(1'b1, 1'b0, 8'h0F, 8'h01, 1'b0);
    check_output("pause_load_done", 32'(bus.DONE), 32'h0);
    check_output("pause_keep_sum",  32'(bus.SUM),  32'hFF);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      check_output("pause_gap_busy", 32'(bus.BUSY), 32'h1);
      check_output("pause_gap_done", 32'(bus.DONE), 32'h0);
    end
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    check_output("pause_7th_done", 32'(bus.DONE), 32'h0);
    apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    check_output("pause_done", 32'(bus.DONE), 32'h1);
    check_output("pause_sum",  32'(bus.SUM),  32'h10);
    check_output("pause_cout", 32'(bus.COUT), 32'h0);

    // Reset mid-operation after 3 shifts, asserted between clock edges
    $display("[TB] reset mid-operation");
    apply_stimulus(1'b1, 1'b0, 8'h5A, 8'h33, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    check_output("arst_sum",  32'(bus.SUM),  32'h00);
    check_output("arst_cout", 32'(bus.COUT), 32'h0);
    check_output("arst_done", 32'(bus.DONE), 32'h0);
    check_output("arst_busy", 32'(bus.BUSY), 32'h0);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'hAA, 8'h55, 1'b1);
      check_output("post_rst_sum",  32'(bus.SUM),  32'h00);
      check_output("post_rst_done", 32'(bus.DONE), 32'h0);
      check_output("post_rst_busy", 32'(bus.BUSY), 32'h0);
    end
    check_output("post_rst_cout", 32'(bus.COUT), 32'h0);

    // LOAD priority: prime SUM=0x8D, start another add, reload mid-shift
    $display("[TB] load priority");
    apply_stimulus(1'b1, 1'b0, 8'h5A, 8'h33, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    check_output("prio_prime_sum", 32'(bus.SUM), 32'h8D);
    apply_stimulus(1'b1, 1'b0, 8'h0F, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    apply_stimulus(1'b1, 1'b1, 8'h01, 8'h02, 1'b0);
    check_output("prio_load_done",   32'(bus.DONE),    32'h0);
    check_output("prio_load_busy",   32'(bus.BUSY),    32'h1);
    check_output("prio_load_sum",    32'(bus.SUM),     32'h8D);
    check_output("prio_load_sumbit", 32'(bus.SUM_BIT), 32'h1);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    check_output("prio_7th_done", 32'(bus.DONE), 32'h0);
    check_output("prio_7th_sum",  32'(bus.SUM),  32'h8D);
    apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    check_output("prio_done", 32'(bus.DONE), 32'h1);
    check_output("prio_sum",  32'(bus.SUM),  32'h03);
    check_output("prio_cout", 32'(bus.COUT), 32'h0);
    check_output("prio_busy", 32'(bus.BUSY), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
